// File: rtl/pll_sup_pkg.sv
// Shared types and helpers for the PLL lock supervisor.
// Optional feature macro: PLL_SUP_LOSS_COUNT_EN (per-channel lock-loss counters).
package pll_sup_pkg;

    // Width of each per-channel lock-loss counter field.
    localparam int LOSS_CNT_W = 8;

    // Width of the encoded channel state, also used for the debug state bus.
    localparam int STATE_W = 3;

    // Per-channel supervisor state. Encodings are fixed so the debug bus
    // can be decoded by software and checkers without the package.
    typedef enum logic [STATE_W-1:0] {
        ST_OFF       = 3'd0,
        ST_PWRDN     = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_SETTLE    = 3'd3,
        ST_LOCKED    = 3'd4,
        ST_FAULT     = 3'd5
    } sup_state_t;

    // Bits needed for a counter that must hold values 0..max_val.
    // Never returns less than 1 so a zero maximum still yields a legal vector.
    function automatic int cnt_width(input int max_val);
        if (max_val < 1) begin
            return 1;
        end
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/pll_sup_channel.sv
// Supervisor for a single PLL: lock synchroniser, glitch filter, power-cycle
// sequencing with bounded retries, and domain reset release after a settle delay.
// Optional feature macro: PLL_SUP_LOSS_COUNT_EN adds a saturating count of
// LOCKED -> PWRDN transitions on loss_cnt.
//
// All outputs are registered and decoded from the next state, so each output
// changes on the same edge as the state transition that implies it.
module pll_sup_channel
    import pll_sup_pkg::*;
#(
    parameter int LOCK_FILT   = 16,
    parameter int TIMEOUT     = 65535,
    parameter int PD_HOLD     = 64,
    parameter int MAX_RETRY   = 3,
    parameter int RST_STAGGER = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  pll_lock,
    output logic                  pd_n,
    output logic                  domain_rst_n,
    output logic                  locked,
    output logic                  fault,
`ifdef PLL_SUP_LOSS_COUNT_EN
    output logic [LOSS_CNT_W-1:0] loss_cnt,
`endif
    output sup_state_t            state
);

    localparam int FILT_W = cnt_width(LOCK_FILT);
    localparam int TMO_W  = cnt_width(TIMEOUT);
    localparam int PD_W   = cnt_width(PD_HOLD);
    localparam int STG_W  = cnt_width(RST_STAGGER);
    localparam int RTY_W  = cnt_width(MAX_RETRY);

    // Terminal values. Each counter stops at its terminal value instead of wrapping.
    localparam logic [FILT_W-1:0] FILT_MAX = FILT_W'(LOCK_FILT);
    localparam logic [TMO_W-1:0]  TMO_MAX  = TMO_W'(TIMEOUT);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [PD_W-1:0]   PD_LAST  = PD_W'(PD_HOLD - 1);
    localparam logic [STG_W-1:0]  STG_LAST = STG_W'(RST_STAGGER - 1);
    localparam logic [RTY_W-1:0]  RTY_MAX  = RTY_W'(MAX_RETRY);

    // Two-stage synchroniser for the asynchronous lock pin.
    logic [1:0]        sync_q, sync_d;
    logic              lock_s;

    sup_state_t        state_q, state_d;
    logic [FILT_W-1:0] filt_q, filt_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [PD_W-1:0]   pd_cnt_q, pd_cnt_d;
    logic [STG_W-1:0]  stg_q, stg_d;
    logic [RTY_W-1:0]  retry_q, retry_d;

    logic pd_n_q, pd_n_d;
    logic drst_n_q, drst_n_d;
    logic locked_q, locked_d;
    logic fault_q, fault_d;

    assign sync_d = {sync_q[0], pll_lock};
    assign lock_s = sync_q[1];

    // Next-state and counter update for the channel FSM.
    always_comb begin
        state_d  = state_q;
        filt_d   = filt_q;
        tmo_d    = tmo_q;
        pd_cnt_d = pd_cnt_q;
        stg_d    = stg_q;
        retry_d  = retry_q;

        if (!en) begin
            // Global disable wins from every state and wipes all progress.
            state_d  = ST_OFF;
            filt_d   = '0;
            tmo_d    = '0;
            pd_cnt_d = '0;
            stg_d    = '0;
            retry_d  = '0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    state_d  = ST_PWRDN;
                    pd_cnt_d = '0;
                end

                ST_PWRDN: begin
                    if (pd_cnt_q == PD_LAST) begin
                        state_d  = ST_WAIT_LOCK;
                        pd_cnt_d = '0;
                        filt_d   = '0;
                        tmo_d    = '0;
                    end else begin
                        pd_cnt_d = pd_cnt_q + 1'b1;
                    end
                end

                ST_WAIT_LOCK: begin
                    // Filter counts consecutive synced-high cycles only.
                    if (lock_s) begin
                        filt_d = (filt_q == FILT_MAX) ? filt_q : filt_q + 1'b1;
                    end else begin
                        filt_d = '0;
                    end
                    tmo_d = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + 1'b1;

                    // Qualification is checked before timeout so it wins a tie.
                    if (filt_q == FILT_MAX) begin
                        state_d = ST_SETTLE;
                        stg_d   = '0;
                        filt_d  = '0;
                        tmo_d   = '0;
                    end else if (tmo_q == TMO_LAST) begin
                        filt_d = '0;
                        tmo_d  = '0;
                        if (retry_q < RTY_MAX) begin
                            retry_d  = retry_q + 1'b1;
                            pd_cnt_d = '0;
                            state_d  = ST_PWRDN;
                        end else begin
                            state_d = ST_FAULT;
                        end
                    end
                end

                ST_SETTLE: begin
                    if (!lock_s) begin
                        // Lock dropped before release: requalify without a power cycle.
                        state_d = ST_WAIT_LOCK;
                        stg_d   = '0;
                        filt_d  = '0;
                        tmo_d   = '0;
                    end else if (stg_q == STG_LAST) begin
                        state_d = ST_LOCKED;
                        stg_d   = '0;
                        retry_d = '0;
                    end else begin
                        stg_d = stg_q + 1'b1;
                    end
                end

                ST_LOCKED: begin
                    // Loss of lock power-cycles the PLL; not counted as a retry.
                    if (!lock_s) begin
                        state_d  = ST_PWRDN;
                        pd_cnt_d = '0;
                    end
                end

                ST_FAULT: begin
                    state_d = ST_FAULT;
                end

                default: begin
                    state_d = ST_OFF;
                end
            endcase
        end
    end

    // Output decode from the next state so outputs are registered with no extra lag.
    always_comb begin
        pd_n_d   = 1'b0;
        drst_n_d = 1'b0;
        locked_d = 1'b0;
        fault_d  = 1'b0;
        case (state_d)
            ST_WAIT_LOCK, ST_SETTLE: begin
                pd_n_d = 1'b1;
            end
            ST_LOCKED: begin
                pd_n_d   = 1'b1;
                drst_n_d = 1'b1;
                locked_d = 1'b1;
            end
            ST_FAULT: begin
                fault_d = 1'b1;
            end
            default: begin
                pd_n_d = 1'b0;
            end
        endcase
    end

    // State, counters, synchroniser and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q   <= '0;
            state_q  <= ST_OFF;
            filt_q   <= '0;
            tmo_q    <= '0;
            pd_cnt_q <= '0;
            stg_q    <= '0;
            retry_q  <= '0;
            pd_n_q   <= 1'b0;
            drst_n_q <= 1'b0;
            locked_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            state_q  <= state_d;
            filt_q   <= filt_d;
            tmo_q    <= tmo_d;
            pd_cnt_q <= pd_cnt_d;
            stg_q    <= stg_d;
            retry_q  <= retry_d;
            pd_n_q   <= pd_n_d;
            drst_n_q <= drst_n_d;
            locked_q <= locked_d;
            fault_q  <= fault_d;
        end
    end

    assign pd_n         = pd_n_q;
    assign domain_rst_n = drst_n_q;
    assign locked       = locked_q;
    assign fault        = fault_q;
    assign state        = state_q;

`ifdef PLL_SUP_LOSS_COUNT_EN
    logic [LOSS_CNT_W-1:0] loss_q, loss_d;

    // Count LOCKED -> PWRDN transitions, saturating; EN does not clear it.
    always_comb begin
        loss_d = loss_q;
        if ((state_q == ST_LOCKED) && (state_d == ST_PWRDN) && (loss_q != '1)) begin
            loss_d = loss_q + 1'b1;
        end
    end

    // Loss counter register, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            loss_q <= '0;
        end else begin
            loss_q <= loss_d;
        end
    end

    assign loss_cnt = loss_q;
`endif

endmodule

// File: rtl/pll_lock_supervisor.sv
// Top-level PLL lock supervisor: one pll_sup_channel per supervised PLL plus
// the registered ALL_LOCKED reduction. Runs on the free-running reference clock.
// Optional feature macro: PLL_SUP_LOSS_COUNT_EN adds the LOSS_CNT output
// (8 bits per channel, channel 0 in the low byte).
// DBG_STATE carries each channel's encoded sup_state_t, channel 0 in the low bits.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int N_CH        = 2,
    parameter int LOCK_FILT   = 16,
    parameter int TIMEOUT     = 65535,
    parameter int PD_HOLD     = 64,
    parameter int MAX_RETRY   = 3,
    parameter int RST_STAGGER = 8
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic                         EN,
    input  logic [N_CH-1:0]              PLL_LOCK,
    output logic [N_CH-1:0]              PLL_POWERDOWN_N,
    output logic [N_CH-1:0]              DOMAIN_RST_N,
    output logic [N_CH-1:0]              LOCKED,
    output logic                         ALL_LOCKED,
    output logic [N_CH-1:0]              FAULT,
`ifdef PLL_SUP_LOSS_COUNT_EN
    output logic [N_CH*LOSS_CNT_W-1:0]   LOSS_CNT,
`endif
    output logic [N_CH*STATE_W-1:0]      DBG_STATE
);

    logic all_locked_q, all_locked_d;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        sup_state_t ch_state;

        pll_sup_channel #(
            .LOCK_FILT   (LOCK_FILT),
            .TIMEOUT     (TIMEOUT),
            .PD_HOLD     (PD_HOLD),
            .MAX_RETRY   (MAX_RETRY),
            .RST_STAGGER (RST_STAGGER)
        ) u_ch (
            .clk          (CLK),
            .rst_n        (RST_N),
            .en           (EN),
            .pll_lock     (PLL_LOCK[i]),
            .pd_n         (PLL_POWERDOWN_N[i]),
            .domain_rst_n (DOMAIN_RST_N[i]),
            .locked       (LOCKED[i]),
            .fault        (FAULT[i]),
`ifdef PLL_SUP_LOSS_COUNT_EN
            .loss_cnt     (LOSS_CNT[i*LOSS_CNT_W +: LOSS_CNT_W]),
`endif
            .state        (ch_state)
        );

        assign DBG_STATE[i*STATE_W +: STATE_W] = ch_state;
    end

    // ALL_LOCKED is the AND of the registered LOCKED bits, one cycle behind them.
    always_comb begin
        all_locked_d = &LOCKED;
    end

    // ALL_LOCKED register.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            all_locked_q <= 1'b0;
        end else begin
            all_locked_q <= all_locked_d;
        end
    end

    assign ALL_LOCKED = all_locked_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor (N_CH=2, LOCK_FILT=4, TIMEOUT=100,
// PD_HOLD=8, MAX_RETRY=2, RST_STAGGER=3). Stimulus phases push the expected
// output-change events (edge number, value) into per-channel queues; an
// independent monitor pops an entry whenever a channel's outputs change.
module tb_pll_lock_supervisor;

    localparam int N_CH = 2;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [1:0] pll_lock;
    logic [1:0] pd_n;
    logic [1:0] drst_n;
    logic [1:0] locked;
    logic       all_locked;
    logic [1:0] fault;
    logic [5:0] dbg_state;
`ifdef PLL_SUP_LOSS_COUNT_EN
    logic [15:0] loss_cnt;
`endif

    pll_lock_supervisor #(
        .N_CH        (N_CH),
        .LOCK_FILT   (4),
        .TIMEOUT     (100),
        .PD_HOLD     (8),
        .MAX_RETRY   (2),
        .RST_STAGGER (3)
    ) dut (
        .CLK             (clk),
        .RST_N           (rst_n),
        .EN              (en),
        .PLL_LOCK        (pll_lock),
        .PLL_POWERDOWN_N (pd_n),
        .DOMAIN_RST_N    (drst_n),
        .LOCKED          (locked),
        .ALL_LOCKED      (all_locked),
        .FAULT           (fault),
`ifdef PLL_SUP_LOSS_COUNT_EN
        .LOSS_CNT        (loss_cnt),
`endif
        .DBG_STATE       (dbg_state)
    );

    // ---------------- clock / edge counter ----------------
    int cyc = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // ---------------- scoreboard state ----------------
    // Entry: {edge number[15:0], value[3:0]}; channel value is {pd_n, drst_n, locked, fault},
    // ALL_LOCKED queue uses bit 0 only.
    logic [19:0] exp_q0[$];
    logic [19:0] exp_q1[$];
    logic [19:0] exp_qa[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    bit  mon_en   = 1'b0;

    // ---------------- driver tasks ----------------
    // Return at the negedge just before edge n, so inputs set now are sampled at edge n.
    task automatic at_edge(input int n);
        while (cyc < n - 1) @(negedge clk);
    endtask

    // Return at the negedge following edge n.
    task automatic at_neg(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic push_ch(input int ch, input int edge_n, input logic [3:0] v);
        logic [15:0] e16;
        e16 = edge_n[15:0];
        if (ch == 0) exp_q0.push_back({e16, v});
        else         exp_q1.push_back({e16, v});
    endtask

    task automatic push_all(input int edge_n, input logic v);
        logic [15:0] e16;
        e16 = edge_n[15:0];
        exp_qa.push_back({e16, 3'b000, v});
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got 0x%0h, required 0x%0h", nm, cyc, act, exp);
        end
    endtask

    // Pop and compare one expected event for queue ch (0, 1, 2 = ALL_LOCKED).
    task automatic check_evt(input int ch, input logic [3:0] act);
        logic [19:0] e;
        bit          got;
        logic [15:0] c16;
        got = 1'b0;
        e   = '0;
        c16 = cyc[15:0];
        case (ch)
            0: if (exp_q0.size() > 0) begin e = exp_q0.pop_front(); got = 1'b1; end
            1: if (exp_q1.size() > 0) begin e = exp_q1.pop_front(); got = 1'b1; end
            default: if (exp_qa.size() > 0) begin e = exp_qa.pop_front(); got = 1'b1; end
        endcase
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL evt_q%0d unexpected change at edge %0d to %b, no event required", ch, cyc, act);
        end else if ((e[19:4] != c16) || (e[3:0] != act)) begin
            n_fail++;
            $display("FAIL evt_q%0d got edge %0d value %b, required edge %0d value %b",
                     ch, cyc, act, e[19:4], e[3:0]);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [3:0] prev0, prev1, cur0, cur1;
        logic       preva, cura;
        prev0 = '0;
        prev1 = '0;
        preva = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                cur0 = {pd_n[0], drst_n[0], locked[0], fault[0]};
                cur1 = {pd_n[1], drst_n[1], locked[1], fault[1]};
                cura = all_locked;
                if (cur0 !== prev0) begin check_evt(0, cur0); prev0 = cur0; end
                if (cur1 !== prev1) begin check_evt(1, cur1); prev1 = cur1; end
                if (cura !== preva) begin check_evt(2, {3'b000, cura}); preva = cura; end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n    = 1'b0;
        en       = 1'b0;
        pll_lock = 2'b00;

        // Reset sampled at edges 1..5, then idle with EN=0.
        at_edge(6);
        rst_n = 1'b1;
        at_neg(9);
        chk("reset_outputs", {23'd0, pd_n, drst_n, locked, fault, all_locked}, 32'd0);
        chk("reset_state", {26'd0, dbg_state}, 32'd0);
        mon_en = 1'b1;

        // Phase 1: enable; ch0 glitchy lock, ch1 clean lock, ALL_LOCKED follows ch1.
        push_ch(0, 18, 4'b1000);
        push_ch(0, 43, 4'b1110);
        push_ch(1, 18, 4'b1000);
        push_ch(1, 69, 4'b1110);
        push_all(70, 1'b1);
        at_edge(10);
        en = 1'b1;
        at_edge(30); pll_lock[0] = 1'b1;
        at_edge(33); pll_lock[0] = 1'b0;
        at_edge(34); pll_lock[0] = 1'b1;
        at_neg(39);
        chk("glitch_still_wait_lock", {29'd0, dbg_state[2:0]}, 32'd2);
        at_neg(41);
        chk("glitch_then_settle", {29'd0, dbg_state[2:0]}, 32'd3);
        at_edge(60); pll_lock[1] = 1'b1;

        // Phase 2: ch0 loss of lock and relock.
        push_ch(0, 82, 4'b0000);
        push_ch(0, 90, 4'b1000);
        push_ch(0, 98, 4'b1110);
        push_all(83, 1'b0);
        push_all(99, 1'b1);
        at_edge(80); pll_lock[0] = 1'b0;
        at_edge(85); pll_lock[0] = 1'b1;
`ifdef PLL_SUP_LOSS_COUNT_EN
        at_neg(100);
        chk("loss_cnt_one", {16'd0, loss_cnt}, 32'h0001);
`endif

        // Phase 3: second loss on ch0, then EN=0 while ch0 is in SETTLE.
        push_ch(0, 112, 4'b0000);
        push_ch(0, 120, 4'b1000);
        push_ch(0, 126, 4'b0000);
        push_ch(1, 126, 4'b0000);
        push_all(113, 1'b0);
        at_edge(110); pll_lock[0] = 1'b0;
        at_edge(113); pll_lock[0] = 1'b1;
        at_neg(125);
        chk("ch0_in_settle", {29'd0, dbg_state[2:0]}, 32'd3);
        at_edge(126); en = 1'b0;
        at_neg(127);
        chk("en_off_outputs", {23'd0, pd_n, drst_n, locked, fault, all_locked}, 32'd0);
        chk("en_off_state", {26'd0, dbg_state}, 32'd0);

        // Phase 4: re-enable with ch1 never locking -> three attempts then FAULT.
        push_ch(0, 138, 4'b1000);
        push_ch(0, 146, 4'b1110);
        push_ch(1, 138, 4'b1000);
        push_ch(1, 238, 4'b0000);
        push_ch(1, 246, 4'b1000);
        push_ch(1, 346, 4'b0000);
        push_ch(1, 354, 4'b1000);
        push_ch(1, 454, 4'b0001);
        at_edge(128); pll_lock[1] = 1'b0;
        at_edge(130); en = 1'b1;
        at_neg(455);
        chk("ch1_fault_state", {29'd0, dbg_state[5:3]}, 32'd5);
        chk("ch0_locked_state", {29'd0, dbg_state[2:0]}, 32'd4);
`ifdef PLL_SUP_LOSS_COUNT_EN
        at_neg(458);
        chk("loss_cnt_two", {16'd0, loss_cnt}, 32'h0002);
`endif

        // Phase 5: EN toggle clears FAULT and retry; ch1 times out once, then locks.
        push_ch(0, 460, 4'b0000);
        push_ch(0, 470, 4'b1000);
        push_ch(0, 478, 4'b1110);
        push_ch(1, 460, 4'b0000);
        push_ch(1, 470, 4'b1000);
        push_ch(1, 570, 4'b0000);
        push_ch(1, 578, 4'b1000);
        push_ch(1, 609, 4'b1110);
        push_all(610, 1'b1);
        at_edge(460); en = 1'b0;
        at_edge(462); en = 1'b1;
        at_neg(571);
        chk("retry_cleared_pwrdn", {29'd0, dbg_state[5:3]}, 32'd1);
        at_edge(600); pll_lock[1] = 1'b1;

        // Phase 6: reset while both channels are LOCKED.
        push_ch(0, 620, 4'b0000);
        push_ch(1, 620, 4'b0000);
        push_all(620, 1'b0);
        at_edge(620); rst_n = 1'b0;
        at_neg(624);
        chk("rst_locked_outputs", {23'd0, pd_n, drst_n, locked, fault, all_locked}, 32'd0);
        chk("rst_locked_state", {26'd0, dbg_state}, 32'd0);
`ifdef PLL_SUP_LOSS_COUNT_EN
        chk("loss_cnt_reset", {16'd0, loss_cnt}, 32'h0000);
`endif
        at_neg(628);

        // Every required event must have been seen.
        n_checks++;
        if (exp_q0.size() != 0) begin
            n_fail++;
            $display("FAIL evt_q0_drain: %0d events left, required 0", exp_q0.size());
        end
        n_checks++;
        if (exp_q1.size() != 0) begin
            n_fail++;
            $display("FAIL evt_q1_drain: %0d events left, required 0", exp_q1.size());
        end
        n_checks++;
        if (exp_qa.size() != 0) begin
            n_fail++;
            $display("FAIL evt_qa_drain: %0d events left, required 0", exp_qa.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
- Parametrised supervisor for N_CH CCC/PLL instances. Each generated PLL wrapper exposes a powerdown and a lock pin.
- Per channel: drives PLL powerdown, qualifies lock with a glitch filter, times out and power-cycles the PLL with bounded retries, and releases a synchronous domain reset after a settle delay.
- Sits at top level between the PLL wrappers and the per-clock-domain reset trees. Runs on a free-running reference clock, never on a PLL output.

Parameters:
- N_CH, 2, number of supervised PLLs (1..8).
- LOCK_FILT, 16, consecutive synced-lock-high cycles required to qualify lock (>=1).
- TIMEOUT, 65535, cycles allowed in WAIT_LOCK before a retry (>=LOCK_FILT+1).
- PD_HOLD, 64, cycles PLL_POWERDOWN_N is held low per power cycle (>=1).
- MAX_RETRY, 3, retries after the first attempt before FAULT.
- RST_STAGGER, 8, cycles from lock qualification to domain reset release (>=1).

Ports:
- CLK  in  1  free-running reference clock.
- RST_N  in  1  synchronous active-low reset.
- EN  in  1  global enable; 0 forces all channels to OFF.
- PLL_LOCK  in  N_CH  raw lock from each PLL, asynchronous to CLK.
- PLL_POWERDOWN_N  out  N_CH  to PLL powerdown pin; 0 = powered down.
- DOMAIN_RST_N  out  N_CH  synchronous active-low reset for each PLL's clock domain.
- LOCKED  out  N_CH  channel in LOCKED state.
- ALL_LOCKED  out  1  AND of LOCKED, registered.
- FAULT  out  N_CH  channel exhausted its retries.

Behaviour:
Reset and sampling:
- Reset value of all outputs is 0. Every channel goes to OFF.
- All outputs are registered.
- Each PLL_LOCK bit passes through a 2-FF synchroniser to form lock_s. The synchroniser is also cleared by reset.

Per-channel FSM:
- OFF: PD_N=0, DOMAIN_RST_N=0. Goes to PWRDN when EN=1.
- PWRDN: PD_N=0. Counts PD_HOLD cycles, then goes to WAIT_LOCK.
- WAIT_LOCK: PD_N=1.
  - filt counter increments while lock_s=1 and clears when lock_s=0.
  - When lock_s=1 for LOCK_FILT consecutive cycles, goes to SETTLE.
  - Timeout counter reaches TIMEOUT: if retry<MAX_RETRY, retry++ and go to PWRDN; otherwise go to FAULT.
  - Qualification and timeout in the same cycle: qualification wins.
- SETTLE: PD_N=1. Counts RST_STAGGER cycles, then goes to LOCKED. lock_s=0 goes to WAIT_LOCK with counters cleared and retry unchanged.
- LOCKED: PD_N=1, DOMAIN_RST_N=1, LOCKED=1. retry is cleared on entry.
  - lock_s=0: DOMAIN_RST_N=0 on the next edge, then go to PWRDN. This loss is not counted as a retry.
- FAULT: PD_N=0, FAULT=1. Held until EN=0 or RST_N=0.

Global rules:
- EN=0 from any state: OFF on the next edge. All counters and retry clear.
- Latency: DOMAIN_RST_N rises exactly 2+LOCK_FILT+RST_STAGGER edges after the first edge that samples PLL_LOCK high, given lock stays high.
- Counters are sized $clog2(max+1). Counters never wrap: each stops at its terminal value.
- Channels are fully independent.
- ALL_LOCKED lags LOCKED by 1 cycle.

Optional Feature:
- Macro PLL_SUP_LOSS_COUNT_EN.
- Defined: adds output LOSS_CNT, out N_CH*8. Each 8-bit field counts LOCKED->PWRDN transitions for its channel, saturates at 255, and clears only on RST_N.
- Undefined: the port and counters are absent. All other behaviour is identical.

Decomposition:
- Package pll_sup_pkg holds:
  - state enum sup_state_t (OFF, PWRDN, WAIT_LOCK, SETTLE, LOCKED, FAULT);
  - the counter-width helper function;
  - the LOSS_CNT width constant (8).
- One sub-module, pll_sup_channel: synchroniser, FSM and counters for a single PLL.
- The top generates N_CH instances and the ALL_LOCKED reduction.

Test Plan:
All scenarios use N_CH=2, LOCK_FILT=4, TIMEOUT=100, PD_HOLD=8, MAX_RETRY=2, RST_STAGGER=3.
1. Reset and idle: RST_N=0 for 5 cycles, EN=0 -> all outputs 0. EN=1 at cycle 0 -> PD_N[i] rises at edge 9.
2. Normal lock: PLL_LOCK[0] high from cycle 30 -> DOMAIN_RST_N[0] and LOCKED[0] rise at cycle 39. ALL_LOCKED stays 0 until ch1 locks, then rises 1 cycle after LOCKED[1].
3. Glitch: PLL_LOCK[0] high 3 cycles, low 1 cycle, then high -> no SETTLE until 4 consecutive synced-high cycles. Release is 9 cycles after the final rise.
4. Timeout/fault: PLL_LOCK[1] never rises -> exactly 3 PD_N[1] low pulses of 8 cycles, each followed by 100 cycles high. FAULT[1]=1 with PD_N[1]=0. Ch0 is unaffected.
5. Loss of lock: ch0 LOCKED, drop PLL_LOCK[0] -> DOMAIN_RST_N[0]=0 three edges later, PD_N low for 8 cycles, relock on restore. LOSS_CNT[7:0]=1 when the macro is defined.
6. Mid-operation: EN=0 in SETTLE, or RST_N=0 in LOCKED -> next edge OFF with all outputs 0. EN=1 restarts a clean sequence with the retry count at 0.
